// File: rtl/clint_mc.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : clint_mc                                                  |
// | Core-local interruptor: trap/MRET CSR sequencing plus machine timer|
// | Rev    : 1.0                                                       |
// +--------------------------------------------------------------------+
module clint_mc #(
  parameter int NUM_IRQ  = 8,
  parameter int XLEN     = 32,
  parameter int TICK_DIV = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               exc_valid_i,
  input  logic [4:0]         exc_cause_i,
  input  logic [XLEN-1:0]    exc_pc_i,
  input  logic [XLEN-1:0]    exc_tval_i,
  input  logic               mret_i,
  input  logic [XLEN-1:0]    next_pc_i,
  input  logic               atom_opt_busy_i,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic [NUM_IRQ-1:0] irq_en_i,
  input  logic               mtie_i,
  input  logic [XLEN-1:0]    csr_mtvec_i,
  input  logic [XLEN-1:0]    csr_mepc_i,
  input  logic [XLEN-1:0]    csr_mstatus_i,
  input  logic               tcmp_we_i,
  input  logic               tcmp_hi_i,
  input  logic [31:0]        tcmp_wdata_i,
  output logic [63:0]        mtime_o,
  output logic               timer_pend_o,
  output logic               flush_flag_o,
  output logic               stall_flag_o,
  output logic               we_o,
  output logic [XLEN-1:0]    waddr_o,
  output logic [XLEN-1:0]    data_o,
  output logic               int_assert_o,
  output logic [XLEN-1:0]    int_addr_o,
  output logic               irq_ack_o,
  output logic [3:0]         irq_ack_id_o
);

  localparam logic [11:0] c_addr_mstatus = 12'h300;
  localparam logic [11:0] c_addr_mepc    = 12'h341;
  localparam logic [11:0] c_addr_mcause  = 12'h342;
  localparam logic [11:0] c_addr_mtval   = 12'h343;
  localparam int          c_pw           = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [c_pw-1:0] c_presc_max = c_pw'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_MEPC    = 3'd1,
    S_MSTATUS = 3'd2,
    S_MTVAL   = 3'd3,
    S_MCAUSE  = 3'd4,
    S_JUMP    = 3'd5,
    S_MRET    = 3'd6
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [63:0]       r_mtime, r_mtimecmp;
  logic [c_pw-1:0]   r_presc;
  logic              r_is_mret;
  logic [XLEN-1:0]   r_tval, r_cause;

  logic [NUM_IRQ-1:0] w_ext_pend;
  logic               w_tmr_pend, w_any_req, w_idle, w_accept, w_take_mret;
  logic [3:0]         w_ext_idx;
  logic [XLEN-1:0]    w_epc, w_tval, w_cause, w_mst_trap, w_mst_mret, w_trap_tgt;
  logic               w_we_nxt, w_assert_nxt;
  logic [XLEN-1:0]    w_waddr_nxt, w_data_nxt, w_addr_nxt;

  assign mtime_o      = r_mtime;
  assign timer_pend_o = (r_mtime >= r_mtimecmp);

  assign w_ext_pend   = irq_i & irq_en_i & {NUM_IRQ{csr_mstatus_i[3]}};
  assign w_tmr_pend   = timer_pend_o & mtie_i & csr_mstatus_i[3];
  assign w_any_req    = exc_valid_i | mret_i | (|w_ext_pend) | w_tmr_pend;
  assign w_idle       = (r_state == S_IDLE);
  assign w_accept     = w_idle & ~atom_opt_busy_i & w_any_req;
  assign w_take_mret  = ~exc_valid_i & mret_i;

  assign flush_flag_o = ~w_idle;
  assign stall_flag_o = w_idle & atom_opt_busy_i & w_any_req;
  assign irq_ack_o    = w_accept & ~exc_valid_i & ~mret_i & (|w_ext_pend);
  assign irq_ack_id_o = irq_ack_o ? w_ext_idx : 4'd0;

  // Descending scan so the lowest pending index is the one left standing.
  always_comb begin
    w_ext_idx = 4'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (w_ext_pend[i]) w_ext_idx = 4'(i);
    end
  end

  always_comb begin
    w_epc   = next_pc_i;
    w_tval  = '0;
    w_cause = XLEN'(7);
    w_cause[XLEN-1] = 1'b1;
    if (exc_valid_i) begin
      w_epc   = exc_pc_i;
      w_tval  = exc_tval_i;
      w_cause = XLEN'(exc_cause_i);
    end else if (|w_ext_pend) begin
      w_cause = XLEN'(5'd16 + {1'b0, w_ext_idx});
      w_cause[XLEN-1] = 1'b1;
    end
  end

  always_comb begin
    w_mst_trap    = csr_mstatus_i;
    w_mst_trap[7] = csr_mstatus_i[3];
    w_mst_trap[3] = 1'b0;
    w_mst_mret    = csr_mstatus_i;
    w_mst_mret[3] = csr_mstatus_i[7];
    w_mst_mret[7] = 1'b1;
    w_trap_tgt    = {csr_mtvec_i[XLEN-1:2], 2'b00};
    if (csr_mtvec_i[1:0] == 2'b01 && r_cause[XLEN-1])
      w_trap_tgt = w_trap_tgt + XLEN'({r_cause[4:0], 2'b00});
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (w_accept) w_state_nxt = w_take_mret ? S_MRET : S_MEPC;
      S_MEPC:    w_state_nxt = S_MSTATUS;
      S_MSTATUS: w_state_nxt = S_MTVAL;
      S_MTVAL:   w_state_nxt = S_MCAUSE;
      S_MCAUSE:  w_state_nxt = S_JUMP;
      S_MRET:    w_state_nxt = S_JUMP;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Port values are prepared for the state being entered, so they line up with it once registered.
  always_comb begin
    w_we_nxt     = 1'b0;
    w_waddr_nxt  = '0;
    w_data_nxt   = '0;
    w_assert_nxt = 1'b0;
    w_addr_nxt   = '0;
    case (w_state_nxt)
      S_MEPC:    begin w_we_nxt = 1'b1; w_waddr_nxt = XLEN'(c_addr_mepc);    w_data_nxt = w_epc;      end
      S_MSTATUS: begin w_we_nxt = 1'b1; w_waddr_nxt = XLEN'(c_addr_mstatus); w_data_nxt = w_mst_trap; end
      S_MTVAL:   begin w_we_nxt = 1'b1; w_waddr_nxt = XLEN'(c_addr_mtval);   w_data_nxt = r_tval;     end
      S_MCAUSE:  begin w_we_nxt = 1'b1; w_waddr_nxt = XLEN'(c_addr_mcause);  w_data_nxt = r_cause;    end
      S_MRET:    begin w_we_nxt = 1'b1; w_waddr_nxt = XLEN'(c_addr_mstatus); w_data_nxt = w_mst_mret; end
      S_JUMP:    begin w_assert_nxt = 1'b1; w_addr_nxt = r_is_mret ? csr_mepc_i : w_trap_tgt; end
      default:   ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_is_mret    <= 1'b0;
      r_tval       <= '0;
      r_cause      <= '0;
      we_o         <= 1'b0;
      waddr_o      <= '0;
      data_o       <= '0;
      int_assert_o <= 1'b0;
      int_addr_o   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_is_mret <= w_take_mret;
        r_tval    <= w_tval;
        r_cause   <= w_cause;
      end
      we_o         <= w_we_nxt;
      waddr_o      <= w_waddr_nxt;
      data_o       <= w_data_nxt;
      int_assert_o <= w_assert_nxt;
      int_addr_o   <= w_addr_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mtime    <= '0;
      r_mtimecmp <= '1;
      r_presc    <= '0;
    end else begin
      if (r_presc == c_presc_max) begin
        r_presc <= '0;
        r_mtime <= r_mtime + 64'd1;
      end else begin
        r_presc <= r_presc + 1'b1;
      end
      if (tcmp_we_i) begin
        if (tcmp_hi_i) r_mtimecmp[63:32] <= tcmp_wdata_i;
        else           r_mtimecmp[31:0]  <= tcmp_wdata_i;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_clint_mc.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : tb_clint_mc                                               |
// | Randomized self-checking bench for clint_mc against a trap model.  |
// | Rev    : 1.0                                                       |
// +--------------------------------------------------------------------+
module tb_clint_mc;
  localparam int NUM_IRQ  = 8;
  localparam int XLEN     = 32;
  localparam int TICK_DIV = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        exc_valid, mret, busy, mtie, tcmp_we, tcmp_hi;
  logic [4:0]  exc_cause;
  logic [31:0] exc_pc, exc_tval, next_pc, mtvec, mepc, mstatus, tcmp_wdata;
  logic [7:0]  irq, irq_en;
  logic [63:0] mtime_o;
  logic        timer_pend_o, flush_flag_o, stall_flag_o, we_o, int_assert_o, irq_ack_o;
  logic [31:0] waddr_o, data_o, int_addr_o;
  logic [3:0]  irq_ack_id_o;

  int          vectors = 0;
  int          miscompares = 0;
  logic [63:0] cyc;
  logic [63:0] cmp_exp;

  always #5 clk = ~clk;

  clint_mc #(.NUM_IRQ(NUM_IRQ), .XLEN(XLEN), .TICK_DIV(TICK_DIV)) dut (
    .clk(clk), .rst_n(rst_n),
    .exc_valid_i(exc_valid), .exc_cause_i(exc_cause), .exc_pc_i(exc_pc), .exc_tval_i(exc_tval),
    .mret_i(mret), .next_pc_i(next_pc), .atom_opt_busy_i(busy),
    .irq_i(irq), .irq_en_i(irq_en), .mtie_i(mtie),
    .csr_mtvec_i(mtvec), .csr_mepc_i(mepc), .csr_mstatus_i(mstatus),
    .tcmp_we_i(tcmp_we), .tcmp_hi_i(tcmp_hi), .tcmp_wdata_i(tcmp_wdata),
    .mtime_o(mtime_o), .timer_pend_o(timer_pend_o),
    .flush_flag_o(flush_flag_o), .stall_flag_o(stall_flag_o),
    .we_o(we_o), .waddr_o(waddr_o), .data_o(data_o),
    .int_assert_o(int_assert_o), .int_addr_o(int_addr_o),
    .irq_ack_o(irq_ack_o), .irq_ack_id_o(irq_ack_id_o)
  );

  // Reference time base: clock edges seen since reset was released.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 64'd0;
    else        cyc <= cyc + 64'd1;
  end

  function automatic logic [63:0] mtime_exp();
    return cyc / TICK_DIV;
  endfunction

  task automatic clear_req();
    exc_valid = 1'b0; mret = 1'b0; irq = 8'h00; mtie = 1'b0; busy = 1'b0;
  endtask

  task automatic write_cmp(input logic hi, input logic [31:0] d);
    @(negedge clk);
    tcmp_we = 1'b1; tcmp_hi = hi; tcmp_wdata = d;
    @(negedge clk);
    tcmp_we = 1'b0;
    if (hi) cmp_exp[63:32] = d;
    else    cmp_exp[31:0]  = d;
  endtask

  // Inputs are already driven for the accept cycle; model the outcome and walk the sequence.
  task automatic apply_and_check(input string tag);
    int          kind, id, last;
    logic [31:0] ea [4];
    logic [31:0] ed [4];
    logic [31:0] epc, tval, cause, tgt, mst;
    logic [7:0]  pe;
    logic        tp, e_we, e_as, e_fl;
    #1;
    pe = mstatus[3] ? (irq & irq_en) : 8'h00;
    tp = (mtime_exp() >= cmp_exp) && mtie && mstatus[3];
    id = -1;
    for (int i = 0; i < NUM_IRQ; i++) if (pe[i] && id < 0) id = i;
    kind = exc_valid ? 1 : mret ? 2 : (id >= 0) ? 3 : tp ? 4 : 0;
    for (int i = 0; i < 4; i++) begin ea[i] = 32'h0; ed[i] = 32'h0; end
    epc   = (kind == 1) ? exc_pc : next_pc;
    tval  = (kind == 1) ? exc_tval : 32'h0;
    cause = (kind == 1) ? {27'h0, exc_cause} : (kind == 3) ? 32'h8000_0010 + 32'(id) : 32'h8000_0007;
    mst   = mstatus & ~32'h88;
    tgt   = 32'h0;
    last  = 0;
    if (kind == 2) begin
      mst   = mst | 32'h80 | (mstatus[7] ? 32'h8 : 32'h0);
      ea[0] = 32'h300; ed[0] = mst;
      tgt   = mepc;
      last  = 2;
    end else if (kind != 0) begin
      mst = mst | (mstatus[3] ? 32'h80 : 32'h0);
      ea[0] = 32'h341; ed[0] = epc;
      ea[1] = 32'h300; ed[1] = mst;
      ea[2] = 32'h343; ed[2] = tval;
      ea[3] = 32'h342; ed[3] = cause;
      tgt   = (mtvec & ~32'h3) + (((mtvec & 32'h3) == 32'h1 && cause[31]) ? (cause & 32'h1f) * 4 : 32'h0);
      last  = 5;
    end
    vectors++;
    if (irq_ack_o !== (kind == 3)) begin
      miscompares++;
      $display("FAIL %s irq_ack: got %0b want %0b", tag, irq_ack_o, (kind == 3));
    end
    if (kind == 3) begin
      vectors++;
      if (irq_ack_id_o !== 4'(id)) begin
        miscompares++;
        $display("FAIL %s irq_ack_id: got %0d want %0d", tag, irq_ack_id_o, id);
      end
    end
    vectors++;
    if (stall_flag_o !== 1'b0) begin
      miscompares++;
      $display("FAIL %s stall: got %0b want 0", tag, stall_flag_o);
    end
    @(negedge clk);
    clear_req();
    for (int k = 1; k <= last + 1; k++) begin
      #1;
      e_we = (k <= last - 1);
      e_as = (k == last);
      e_fl = (k <= last);
      vectors++;
      if (we_o !== e_we) begin
        miscompares++;
        $display("FAIL %s we k=%0d: got %0b want %0b", tag, k, we_o, e_we);
      end
      if (e_we) begin
        vectors++;
        if (waddr_o !== ea[k-1] || data_o !== ed[k-1]) begin
          miscompares++;
          $display("FAIL %s csr k=%0d: got %h=%h want %h=%h", tag, k, waddr_o, data_o, ea[k-1], ed[k-1]);
        end
      end
      vectors++;
      if (int_assert_o !== e_as) begin
        miscompares++;
        $display("FAIL %s int_assert k=%0d: got %0b want %0b", tag, k, int_assert_o, e_as);
      end
      if (e_as) begin
        vectors++;
        if (int_addr_o !== tgt) begin
          miscompares++;
          $display("FAIL %s int_addr: got %h want %h", tag, int_addr_o, tgt);
        end
      end
      vectors++;
      if (flush_flag_o !== e_fl) begin
        miscompares++;
        $display("FAIL %s flush k=%0d: got %0b want %0b", tag, k, flush_flag_o, e_fl);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    vectors++;
    if ({we_o, int_assert_o, flush_flag_o, stall_flag_o, irq_ack_o, timer_pend_o} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset flags: got %b want 000000",
               {we_o, int_assert_o, flush_flag_o, stall_flag_o, irq_ack_o, timer_pend_o});
    end
    vectors++;
    if (mtime_o !== 64'h0 || waddr_o !== 32'h0 || data_o !== 32'h0 || int_addr_o !== 32'h0) begin
      miscompares++;
      $display("FAIL reset values: mtime %h waddr %h data %h addr %h want all 0", mtime_o, waddr_o, data_o, int_addr_o);
    end
    cmp_exp = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_timer();
    write_cmp(1'b0, 32'd8);
    write_cmp(1'b1, 32'd0);
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      #1;
      vectors++;
      if (mtime_o !== mtime_exp()) begin
        miscompares++;
        $display("FAIL timer mtime cyc=%0d: got %0d want %0d", cyc, mtime_o, mtime_exp());
      end
      vectors++;
      if (timer_pend_o !== (mtime_exp() >= cmp_exp)) begin
        miscompares++;
        $display("FAIL timer pend cyc=%0d: got %0b want %0b", cyc, timer_pend_o, (mtime_exp() >= cmp_exp));
      end
    end
    @(negedge clk);
    mtie = 1'b1; mstatus = 32'h8; mtvec = 32'h8000_0001; next_pc = 32'h0000_2000;
    apply_and_check("timer_trap");
  endtask

  task automatic test_exception();
    @(negedge clk);
    exc_valid = 1'b1; exc_cause = 5'd11; exc_pc = 32'h100; exc_tval = 32'h0;
    mtvec = 32'h8000_0001; mstatus = 32'h8;
    apply_and_check("exception");
  endtask

  task automatic test_ext_irq();
    @(negedge clk);
    irq = 8'h0C; irq_en = 8'hFF; mstatus = 32'h8; mtvec = 32'h8000_0001; next_pc = 32'h0000_0404;
    apply_and_check("ext_irq");
  endtask

  task automatic test_exc_vs_irq();
    @(negedge clk);
    exc_valid = 1'b1; exc_cause = 5'd2; exc_pc = 32'h200; exc_tval = 32'hDEAD_BEEF;
    irq = 8'h01; irq_en = 8'hFF; mstatus = 32'h8; mtvec = 32'h8000_0001;
    apply_and_check("exc_vs_irq");
  endtask

  task automatic test_busy_stall();
    @(negedge clk);
    irq = 8'h10; irq_en = 8'hFF; mstatus = 32'h8; mtvec = 32'h4000_0000; busy = 1'b1;
    for (int n = 0; n < 3; n++) begin
      #1;
      vectors++;
      if (stall_flag_o !== 1'b1 || we_o !== 1'b0 || flush_flag_o !== 1'b0 || irq_ack_o !== 1'b0) begin
        miscompares++;
        $display("FAIL busy n=%0d: stall %0b we %0b flush %0b ack %0b want 1 0 0 0",
                 n, stall_flag_o, we_o, flush_flag_o, irq_ack_o);
      end
      @(negedge clk);
    end
    busy = 1'b0;
    apply_and_check("busy_release");
  endtask

  task automatic test_mret();
    @(negedge clk);
    mret = 1'b1; mstatus = 32'h80; mepc = 32'h1234_5678;
    apply_and_check("mret");
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      mstatus   = $urandom & ~32'h88;
      mstatus[3] = 1'($urandom_range(0, 1));
      mstatus[7] = 1'($urandom_range(0, 1));
      irq       = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
      irq_en    = 8'($urandom);
      exc_valid = ($urandom_range(0, 3) == 0);
      mret      = ($urandom_range(0, 3) == 0);
      mtie      = 1'($urandom_range(0, 1));
      exc_cause = 5'($urandom_range(0, 11));
      exc_pc    = $urandom; exc_tval = $urandom; next_pc = $urandom; mepc = $urandom;
      mtvec     = {$urandom, 2'b00};
      mtvec[0]  = 1'($urandom_range(0, 1));
      apply_and_check($sformatf("random%0d", n));
    end
  endtask

  task automatic test_reset_mid_seq();
    @(negedge clk);
    exc_valid = 1'b1; exc_cause = 5'd4; exc_pc = 32'h300; exc_tval = 32'h0;
    mtvec = 32'h8000_0000; mstatus = 32'h8;
    @(negedge clk);
    clear_req();
    @(negedge clk);
    #1;
    vectors++;
    if (we_o !== 1'b1 || waddr_o !== 32'h300 || data_o !== 32'h80) begin
      miscompares++;
      $display("FAIL midreset mstatus write: we %0b %h=%h want 1 300=80", we_o, waddr_o, data_o);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (we_o !== 1'b0 || flush_flag_o !== 1'b0 || int_assert_o !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset async: we %0b flush %0b assert %0b want 0", we_o, flush_flag_o, int_assert_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cmp_exp = 64'hFFFF_FFFF_FFFF_FFFF;
    for (int n = 0; n < 7; n++) begin
      @(negedge clk);
      #1;
      vectors++;
      if (we_o !== 1'b0 || int_assert_o !== 1'b0 || flush_flag_o !== 1'b0) begin
        miscompares++;
        $display("FAIL midreset after n=%0d: we %0b assert %0b flush %0b want 0",
                 n, we_o, int_assert_o, flush_flag_o);
      end
    end
  endtask

  initial begin
    clear_req();
    exc_cause = 5'd0; exc_pc = 32'h0; exc_tval = 32'h0; next_pc = 32'h0;
    irq_en = 8'h00; mtvec = 32'h0; mepc = 32'h0; mstatus = 32'h0;
    tcmp_we = 1'b0; tcmp_hi = 1'b0; tcmp_wdata = 32'h0;
    cmp_exp = 64'hFFFF_FFFF_FFFF_FFFF;
    test_reset();
    test_timer();
    test_exception();
    test_ext_irq();
    test_exc_vs_irq();
    test_busy_stall();
    test_mret();
    test_random();
    test_reset_mid_seq();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
